// File: rtl/idma_desc64_reader_gater_q_if.sv
// Handshake bundle between the desc64 reader R channel, the flush command
// source and the burst gater. The slave modport is the gater's view.
interface idma_desc64_reader_gater_q_if #(
  parameter int unsigned FlushWidth = 4
);
  logic [FlushWidth-1:0] flush_i;
  logic                  flush_valid_i;
  logic                  flush_ready_o;
  logic                  r_valid_i;
  logic                  r_ready_o;
  logic                  r_last_i;
  logic                  r_valid_o;
  logic                  r_ready_i;
  logic                  busy_o;
  logic                  drop_o;

  modport slave (
    input  flush_i, flush_valid_i, r_valid_i, r_last_i, r_ready_i,
    output flush_ready_o, r_ready_o, r_valid_o, busy_o, drop_o
  );

  modport master (
    output flush_i, flush_valid_i, r_valid_i, r_last_i, r_ready_i,
    input  flush_ready_o, r_ready_o, r_valid_o, busy_o, drop_o
  );
endinterface

// File: rtl/idma_desc64_reader_gater_q.sv
// Queued burst gater for the desc64 descriptor-reader R channel.
// Flush commands are queued; each one lets the in-flight burst finish and
// then swallows a given number of bursts (or beats) by holding ready high
// and hiding valid from the descriptor parser.
module idma_desc64_reader_gater_q #(
  parameter int unsigned FlushWidth = 4,
  parameter int unsigned FlushDepth = 4,
  parameter bit          CountBeats = 1'b0
) (
  input logic                          clk_i,
  input logic                          rst_i,
  idma_desc64_reader_gater_q_if.slave  bus
);

  localparam int unsigned PtrW = (FlushDepth > 1) ? $clog2(FlushDepth) : 1;
  localparam int unsigned CntW = $clog2(FlushDepth + 1);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_LAST = 2'd1,
    DROP      = 2'd2
  } state_e;

  state_e                state_q;
  logic [FlushWidth-1:0] rem_q;
  logic                  in_burst_q;

  logic [FlushWidth-1:0] fifo_q [FlushDepth];
  logic [PtrW-1:0]       wr_ptr_q;
  logic [PtrW-1:0]       rd_ptr_q;
  logic [CntW-1:0]       count_q;

  logic                  fifo_empty;
  logic                  fifo_full;
  logic                  push;
  logic                  pop;
  logic [FlushWidth-1:0] head;
  logic                  gating;
  logic                  pass_hs;
  logic                  unit_done;

  function automatic logic [PtrW-1:0] next_ptr(input logic [PtrW-1:0] p);
    return (p == PtrW'(FlushDepth - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign fifo_empty = (count_q == '0);
  assign fifo_full  = (count_q == CntW'(FlushDepth));
  assign push       = bus.flush_valid_i && !fifo_full;
  assign pop        = (state_q == IDLE) && !fifo_empty;
  assign head       = fifo_q[rd_ptr_q];

  assign gating     = (state_q == DROP);
  assign pass_hs    = !gating && bus.r_valid_i && bus.r_ready_i;
  assign unit_done  = gating && bus.r_valid_i && (CountBeats || bus.r_last_i);

  assign bus.flush_ready_o = !fifo_full;
  assign bus.r_valid_o     = gating ? 1'b0 : bus.r_valid_i;
  assign bus.r_ready_o     = gating ? 1'b1 : bus.r_ready_i;
  assign bus.drop_o        = unit_done;
  assign bus.busy_o        = (state_q != IDLE) || !fifo_empty;

  // Command storage; contents need no reset because occupancy guards reads.
  always_ff @(posedge clk_i) begin
    if (push) begin
      fifo_q[wr_ptr_q] <= bus.flush_i;
    end
  end

  // Queue pointers and occupancy; push and pop may coincide.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        wr_ptr_q <= next_ptr(wr_ptr_q);
      end
      if (pop) begin
        rd_ptr_q <= next_ptr(rd_ptr_q);
      end
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Tracks whether a pass-through burst has started but not yet ended.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_burst_q <= 1'b0;
    end else if (gating) begin
      in_burst_q <= 1'b0;
    end else if (pass_hs) begin
      in_burst_q <= !bus.r_last_i;
    end
  end

  // Gating FSM: pick up a command, let the current burst finish, then drop.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      rem_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (pop && (head != '0)) begin
            rem_q <= head;
            if (in_burst_q || (pass_hs && !bus.r_last_i)) begin
              state_q <= WAIT_LAST;
            end else begin
              state_q <= DROP;
            end
          end
        end
        WAIT_LAST: begin
          if (pass_hs && bus.r_last_i) begin
            state_q <= DROP;
          end
        end
        DROP: begin
          if (unit_done) begin
            rem_q <= rem_q - FlushWidth'(1);
            if (rem_q == FlushWidth'(1)) begin
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_idma_desc64_reader_gater_q.sv
// Bench for the queued burst gater. Three gaters with different parameters
// (default, shallow queue, beat counting) see the same stimulus and are each
// compared every cycle against a queue-based behavioural model.
module tb_idma_desc64_reader_gater_q;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  idma_desc64_reader_gater_q_if #(.FlushWidth(4)) bus0 ();
  idma_desc64_reader_gater_q_if #(.FlushWidth(4)) bus1 ();
  idma_desc64_reader_gater_q_if #(.FlushWidth(4)) bus2 ();

  idma_desc64_reader_gater_q #(.FlushWidth(4), .FlushDepth(4), .CountBeats(1'b0)) u_dut0 (
    .clk_i(clk), .rst_i(rst), .bus(bus0)
  );
  idma_desc64_reader_gater_q #(.FlushWidth(4), .FlushDepth(2), .CountBeats(1'b0)) u_dut1 (
    .clk_i(clk), .rst_i(rst), .bus(bus1)
  );
  idma_desc64_reader_gater_q #(.FlushWidth(4), .FlushDepth(4), .CountBeats(1'b1)) u_dut2 (
    .clk_i(clk), .rst_i(rst), .bus(bus2)
  );

  int total = 0;
  int bad   = 0;

  // Behavioural model: a list of pending counts, units left to discard,
  // and whether we are still waiting for the current burst to end.
  int depthOf [3] = '{4, 2, 4};
  bit beatsOf [3] = '{1'b0, 1'b0, 1'b1};
  int mFifo [3][8];
  int mCnt [3];
  int mRem [3];
  bit mWait [3];
  bit mInBurst [3];

  task automatic resetModel(input int i);
    mCnt[i]     = 0;
    mRem[i]     = 0;
    mWait[i]    = 1'b0;
    mInBurst[i] = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s observed=%0h expected=%0h at %0t", tag, observed, expected, $time);
    end
  endtask

  // One clock cycle: drive inputs, check all outputs, advance the model.
  task automatic applyStimulus(input bit r, input bit fv, input int fl,
                               input bit rv, input bit rr, input bit rl);
    logic [4:0] obs [3];
    @(negedge clk);
    rst = r;
    bus0.flush_valid_i = fv; bus0.flush_i = 4'(fl);
    bus0.r_valid_i = rv; bus0.r_ready_i = rr; bus0.r_last_i = rl;
    bus1.flush_valid_i = fv; bus1.flush_i = 4'(fl);
    bus1.r_valid_i = rv; bus1.r_ready_i = rr; bus1.r_last_i = rl;
    bus2.flush_valid_i = fv; bus2.flush_i = 4'(fl);
    bus2.r_valid_i = rv; bus2.r_ready_i = rr; bus2.r_last_i = rl;
    #1;
    obs[0] = {bus0.r_valid_o, bus0.r_ready_o, bus0.drop_o, bus0.flush_ready_o, bus0.busy_o};
    obs[1] = {bus1.r_valid_o, bus1.r_ready_o, bus1.drop_o, bus1.flush_ready_o, bus1.busy_o};
    obs[2] = {bus2.r_valid_o, bus2.r_ready_o, bus2.drop_o, bus2.flush_ready_o, bus2.busy_o};
    for (int i = 0; i < 3; i++) begin
      int  wasCnt;
      bit  gating;
      bit  unit;
      int  h;
      wasCnt = mCnt[i];
      gating = (mRem[i] > 0) && !mWait[i];
      unit   = gating && rv && (beatsOf[i] || rl);
      checkOutput($sformatf("u%0d.r_valid_o", i), 32'(obs[i][4]), 32'(gating ? 1'b0 : rv));
      checkOutput($sformatf("u%0d.r_ready_o", i), 32'(obs[i][3]), 32'(gating ? 1'b1 : rr));
      checkOutput($sformatf("u%0d.drop_o", i), 32'(obs[i][2]), 32'(unit));
      checkOutput($sformatf("u%0d.flush_ready_o", i), 32'(obs[i][1]), 32'(wasCnt < depthOf[i]));
      checkOutput($sformatf("u%0d.busy_o", i), 32'(obs[i][0]), 32'((mRem[i] > 0) || (wasCnt > 0)));
      if (r) begin
        resetModel(i);
      end else begin
        if (mRem[i] == 0) begin
          if (wasCnt > 0) begin
            h = mFifo[i][0];
            for (int k = 0; k < 7; k++) mFifo[i][k] = mFifo[i][k+1];
            mCnt[i]--;
            if (h != 0) begin
              mRem[i]  = h;
              mWait[i] = mInBurst[i] || (rv && rr && !rl);
            end
          end
        end else if (mWait[i]) begin
          if (rv && rr && rl) mWait[i] = 1'b0;
        end else if (unit) begin
          mRem[i]--;
        end
        if (gating)        mInBurst[i] = 1'b0;
        else if (rv && rr) mInBurst[i] = !rl;
        if (fv && (wasCnt < depthOf[i])) begin
          mFifo[i][mCnt[i]] = fl;
          mCnt[i]++;
        end
      end
    end
  endtask

  initial begin
    int pv, pr, pl, pf;
    bus0.flush_valid_i = 1'b0; bus0.flush_i = '0; bus0.r_valid_i = 1'b0; bus0.r_ready_i = 1'b0; bus0.r_last_i = 1'b0;
    bus1.flush_valid_i = 1'b0; bus1.flush_i = '0; bus1.r_valid_i = 1'b0; bus1.r_ready_i = 1'b0; bus1.r_last_i = 1'b0;
    bus2.flush_valid_i = 1'b0; bus2.flush_i = '0; bus2.r_valid_i = 1'b0; bus2.r_ready_i = 1'b0; bus2.r_last_i = 1'b0;
    for (int i = 0; i < 3; i++) resetModel(i);

    // Reset, then idle pass-through of three 4-beat bursts with random ready.
    applyStimulus(1, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 1, 1, 0);
    for (int b = 0; b < 12; b++)
      applyStimulus(0, 0, 0, 1, 1'($urandom_range(1)), (b % 4) == 3);

    // Push 2 in the middle of a burst, then stream four bursts.
    for (int b = 0; b < 16; b++)
      applyStimulus(0, b == 1, 2, 1, 1, (b % 4) == 3);
    repeat (3) applyStimulus(0, 0, 0, 0, 0, 0);

    // Zero-count entry followed by a count of one.
    applyStimulus(0, 1, 0, 0, 0, 0);
    applyStimulus(0, 1, 1, 0, 0, 0);
    for (int b = 0; b < 12; b++)
      applyStimulus(0, 0, 0, 1, 1, (b % 4) == 3);

    // Push 5 while idle, then beats with random last.
    applyStimulus(0, 1, 5, 0, 0, 0);
    for (int b = 0; b < 24; b++)
      applyStimulus(0, 0, 0, 1, 1, 1'($urandom_range(1)));

    // Back-to-back pushes of 1 held long enough to fill the shallow queue.
    for (int b = 0; b < 4; b++)
      applyStimulus(0, 1, 1, 0, 0, 0);
    for (int b = 0; b < 24; b++)
      applyStimulus(0, 0, 0, 1, 1, (b % 4) == 3);

    // Reset while dropping with units outstanding.
    applyStimulus(0, 1, 3, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 1, 1, 1);
    applyStimulus(1, 0, 0, 1, 1, 0);
    for (int b = 0; b < 6; b++)
      applyStimulus(0, 0, 0, 1, 1, (b % 4) == 3);

    // Randomized traffic with varying densities.
    for (int ph = 0; ph < 20; ph++) begin
      pv = $urandom_range(95, 30);
      pr = $urandom_range(100, 40);
      pl = $urandom_range(60, 10);
      pf = $urandom_range(40, 2);
      for (int c = 0; c < 200; c++) begin
        int fl;
        fl = ($urandom_range(3) == 0) ? $urandom_range(15) : $urandom_range(3);
        applyStimulus($urandom_range(399) == 0,
                      $urandom_range(99) < pf, fl,
                      $urandom_range(99) < pv,
                      $urandom_range(99) < pr,
                      $urandom_range(99) < pl);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
